mac_dot_sequencer: RTL and testbench

- Controller that sequences a MAC datapath through one dot product of run-time length LEN.
- Accepts a start command, clears the MAC, and streams LEN operand pairs from an upstream valid/ready source into the MAC.
- Waits for the final accumulate, then presents the result on a valid/ready output.
- Sits between the operand fetch logic and the MAC unit; the MAC is external and driven through the mac_* ports.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_len_counter.sv | 47 ++++
 rtl/mac_dot_sequencer.sv | 111 +++++++++++
 tb/tb_mac_dot_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_pkg : shared defaults and state encoding for the MAC dot sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_len_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_len_counter : latched length, accepted-pair count and last-pair flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module mac_len_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             inc_i,
  output logic             last_o,
  output logic             zero_o
);

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load_i) begin
      len_d = len_i;
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while len_q is non-zero; the FSM skips RUN otherwise.
  assign last_o = (cnt_q == (len_q - LEN_W'(1)));
  assign zero_o = (len_q == '0);

endmodule
`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_dot_sequencer : drives an external MAC through one dot product of LEN
// Revision: 1.0
// ---------------------------------------------------------------------------
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_x_i,
  input  logic [DATA_W-1:0] in_w_i,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic [DATA_W-1:0] mac_x_o,
  output logic [DATA_W-1:0] mac_w_o,
  input  logic [ACC_W-1:0]  mac_acc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_result_o
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               load;
  logic               hs;
  logic               last;
  logic               zero_len;

  mac_len_counter #(
    .LEN_W (LEN_W)
  ) u_len_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .len_i  (len_i),
    .inc_i  (hs),
    .last_o (last),
    .zero_o (zero_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    load        = 1'b0;
    hs          = 1'b0;
    busy_o      = 1'b1;
    in_ready_o  = 1'b0;
    mac_clr_o   = 1'b0;
    mac_en_o    = 1'b0;
    mac_x_o     = '0;
    mac_w_o     = '0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          load    = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mac_clr_o = 1'b1;
        state_d   = zero_len ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        in_ready_o = 1'b1;
        hs         = in_valid_i;
        if (hs) begin
          mac_en_o = 1'b1;
          mac_x_o  = in_x_i;
          mac_w_o  = in_w_i;
          if (last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final accumulate has landed on mac_acc by this cycle.
        result_d = mac_acc_i;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_dot_sequencer : randomized self-checking bench with a behavioural MAC
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mac_dot_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_w;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_x;
  logic [DATA_W-1:0] mac_w;
  logic [ACC_W-1:0]  mac_acc = '0;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_result;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] xs [256];
  logic [DATA_W-1:0] ws [256];

  always #5 clk = ~clk;

  mac_dot_sequencer #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
    .busy_o       (busy),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_x_i       (in_x),
    .in_w_i       (in_w),
    .mac_clr_o    (mac_clr),
    .mac_en_o     (mac_en),
    .mac_x_o      (mac_x),
    .mac_w_o      (mac_w),
    .mac_acc_i    (mac_acc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result)
  );

  // External MAC unit: not tied to the sequencer reset, cleared only by mac_clr.
  always @(posedge clk) begin
    if (mac_clr)     mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + ACC_W'(mac_x) * ACC_W'(mac_w);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     busy,       0);
    chk({tag, "_in_ready"}, in_ready,   0);
    chk({tag, "_mac_clr"},  mac_clr,    0);
    chk({tag, "_mac_en"},   mac_en,     0);
    chk({tag, "_mac_xw"},   {mac_x, mac_w}, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_result"}, out_result, 0);
  endtask

  // One full command: pairs come from xs/ws[0..n-1]; gap cycles of in_valid=0
  // between pairs (fixed or random up to g); out_ready rises rdy cycles after
  // out_valid is first seen.
  task automatic run_cmd(input int n, input int g, input bit g_rand, input int rdy,
                         input bit poke_start);
    int idx, cyc, en_cnt, clr_cnt, gap, t_valid, extra;
    bit fin;
    logic [ACC_W-1:0] exp;
    exp = '0;
    for (int i = 0; i < n; i++)
      exp = ACC_W'(int'(exp) + int'(xs[i]) * int'(ws[i]));
    idx = 0; en_cnt = 0; clr_cnt = 0; t_valid = -1; extra = 0; fin = 0; cyc = 0;
    gap = g_rand ? int'($urandom_range(0, g)) : 0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 2);
      len   = LEN_W'($urandom);
      if (idx < n && gap == 0) begin
        in_valid = 1'b1; in_x = xs[idx]; in_w = ws[idx];
      end else begin
        in_valid = (idx >= n);
        in_x = DATA_W'($urandom); in_w = DATA_W'($urandom);
      end
      out_ready = (t_valid >= 0) && (cyc - t_valid >= rdy);
      #1;
      clr_cnt += int'(mac_clr);
      en_cnt  += int'(mac_en);
      chk("clr_en_exclusive", mac_clr & mac_en, 0);
      if (in_valid && in_ready) begin
        if (idx >= n) extra++;
        else begin
          chk("mac_en_on_hs", mac_en, 1);
          chk("mac_xw_pass", {mac_x, mac_w}, {xs[idx], ws[idx]});
          idx++;
          gap = g_rand ? int'($urandom_range(0, g)) : g;
        end
      end else begin
        if (in_ready) chk("stall_mac_quiet", {mac_en, mac_x, mac_w}, 0);
        if (!in_valid && gap > 0) gap--;
      end
      if (out_valid) begin
        if (t_valid < 0) begin
          t_valid = cyc;
          chk("result", out_result, exp);
          if (g == 0) chk("latency", cyc, n + 3);
        end else begin
          chk("result_hold", out_result, exp);
        end
        if (out_ready) fin = 1;
      end
    end
    chk("timeout", fin, 1);
    chk("mac_en_count", en_cnt, n);
    chk("mac_clr_count", clr_cnt, 1);
    chk("extra_accept", extra, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_x = '0; in_w = '0; out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset");

    // Basic, then stalls with slow downstream
    xs[0] = 2; ws[0] = 3; xs[1] = 4; ws[1] = 5; xs[2] = 6; ws[2] = 7;
    run_cmd(3, 0, 1'b0, 0, 1'b0);
    run_cmd(3, 2, 1'b0, 5, 1'b0);
    // Zero length
    run_cmd(0, 0, 1'b0, 0, 1'b0);
    // Start during RUN ignored, then a back-to-back command
    run_cmd(3, 0, 1'b0, 0, 1'b1);
    xs[0] = 10; ws[0] = 10; xs[1] = 1; ws[1] = 5;
    run_cmd(2, 0, 1'b0, 0, 1'b0);

    // Reset mid-RUN after the 2nd of 3 pairs
    xs[0] = 2; ws[0] = 3; xs[1] = 4; ws[1] = 5; xs[2] = 6; ws[2] = 7;
    @(negedge clk); start = 1'b1; len = 3; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_x = xs[i]; in_w = ws[i];
    end
    @(negedge clk); rst_n = 1'b0; in_x = xs[2]; in_w = ws[2];
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    #1;
    chk_all_zero("mid_reset_hold");
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    xs[0] = 255; ws[0] = 255;
    run_cmd(1, 0, 1'b0, 0, 1'b0);

    // Wrap
    xs[1] = 255; ws[1] = 255;
    run_cmd(2, 0, 1'b0, 1, 1'b0);

    // Randomized commands
    for (int k = 0; k < 12; k++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        xs[i] = DATA_W'($urandom);
        ws[i] = DATA_W'($urandom);
      end
      run_cmd(n, int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
